// File: rtl/rvga_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : rvga_decode_unit
// Purpose  : RV32I decode stage. Classifies opcodes, builds immediates,
//            extracts register/function fields, flags illegal opcodes and
//            issues an early JAL redirect. Registered output, optional skid.
// Revision : 1.0 - initial release
// ============================================================================
module rvga_decode_unit #(
    parameter int XLEN         = 32,
    parameter bit SKID         = 1'b1,
    parameter bit REDIRECT_JAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ifetch_decode_valid,
    output logic            ifetch_decode_ready,
    input  logic [31:0]     ifetch_decode_instruction,
    input  logic [XLEN-1:0] ifetch_decode_pc,
    output logic            decode_exec_valid,
    input  logic            decode_exec_ready,
    output logic [XLEN-1:0] decode_exec_pc,
    output logic [6:0]      decode_exec_opcode,
    output logic [2:0]      decode_exec_inst_type,
    output logic [4:0]      decode_exec_rd,
    output logic [4:0]      decode_exec_rs1,
    output logic [4:0]      decode_exec_rs2,
    output logic [2:0]      decode_exec_funct3,
    output logic [6:0]      decode_exec_funct7,
    output logic [XLEN-1:0] decode_exec_imm,
    output logic            decode_exec_illegal,
    output logic            decode_hazard_pc_redirect,
    output logic [XLEN-1:0] decode_hazard_redirect_target
);

    typedef logic [XLEN-1:0] rvga_word;

    // rvga_inst_type encoding
    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        rvga_word   pc;
        logic [6:0] opcode;
        logic [2:0] itype;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [6:0] funct7;
        rvga_word   imm;
        logic       illegal;
    } bundle_t;

    logic [31:0] w_inst;
    bundle_t     w_dec;
    bundle_t     w_out;
    logic        w_out_valid;
    logic        w_ready;
    logic        w_in_xfer;
    logic        w_out_xfer;

    assign w_inst = ifetch_decode_instruction;

    // Combinational decode of the presented instruction
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = ifetch_decode_pc;
        w_dec.opcode  = w_inst[6:0];
        w_dec.rd      = w_inst[11:7];
        w_dec.rs1     = w_inst[19:15];
        w_dec.rs2     = w_inst[24:20];
        w_dec.funct3  = w_inst[14:12];
        w_dec.funct7  = w_inst[31:25];
        w_dec.itype   = TYPE_R;
        w_dec.imm     = '0;
        w_dec.illegal = 1'b0;
        case (w_inst[6:0])
            OPC_LUI, OPC_AUIPC: begin
                w_dec.itype = TYPE_U;
                w_dec.imm   = {w_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                w_dec.itype = TYPE_J;
                w_dec.imm   = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20],
                               w_inst[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                w_dec.itype = TYPE_I;
                w_dec.imm   = {{20{w_inst[31]}}, w_inst[31:20]};
            end
            OPC_BRANCH: begin
                w_dec.itype = TYPE_B;
                w_dec.imm   = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25],
                               w_inst[11:8], 1'b0};
            end
            OPC_STORE: begin
                w_dec.itype = TYPE_S;
                w_dec.imm   = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
            end
            OPC_OP: begin
                w_dec.itype = TYPE_R;
            end
            default: begin
                w_dec.itype   = TYPE_R;
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Flush wins over any handshake: a flushed input is simply not taken
    assign w_in_xfer  = ifetch_decode_valid & w_ready & ~flush;
    assign w_out_xfer = w_out_valid & decode_exec_ready;

    generate
        if (SKID) begin : g_skid
            localparam logic [1:0] ST_EMPTY = 2'd0;
            localparam logic [1:0] ST_ONE   = 2'd1;
            localparam logic [1:0] ST_TWO   = 2'd2;

            logic [1:0] state_q, state_d;
            bundle_t    out_q, out_d;
            bundle_t    skid_q, skid_d;
            logic       ready_q;

            // Occupancy FSM: output register plus one overflow entry
            always_comb begin
                state_d = state_q;
                out_d   = out_q;
                skid_d  = skid_q;
                case (state_q)
                    ST_EMPTY: begin
                        if (w_in_xfer) begin
                            out_d   = w_dec;
                            state_d = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_in_xfer && w_out_xfer) begin
                            out_d = w_dec;
                        end else if (w_in_xfer) begin
                            skid_d  = w_dec;
                            state_d = ST_TWO;
                        end else if (w_out_xfer) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        if (w_out_xfer) begin
                            out_d   = skid_q;
                            state_d = ST_ONE;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
                if (flush) begin
                    state_d = ST_EMPTY;
                end
            end

            // State/data registers; ready is precomputed from next state
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= ST_EMPTY;
                    out_q   <= '0;
                    skid_q  <= '0;
                    ready_q <= 1'b1;
                end else begin
                    state_q <= state_d;
                    out_q   <= out_d;
                    skid_q  <= skid_d;
                    ready_q <= (state_d != ST_TWO);
                end
            end

            assign w_out       = out_q;
            assign w_out_valid = (state_q != ST_EMPTY);
            assign w_ready     = ready_q;
        end else begin : g_noskid
            logic    valid_q;
            bundle_t out_q;

            // Single output register with pass-through ready
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    out_q   <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (w_in_xfer) begin
                    valid_q <= 1'b1;
                    out_q   <= w_dec;
                end else if (w_out_xfer) begin
                    valid_q <= 1'b0;
                end
            end

            assign w_out       = out_q;
            assign w_out_valid = valid_q;
            // Ready stays high while reset is held so upstream never stalls on it
            assign w_ready     = ~valid_q | decode_exec_ready | rst;
        end
    endgenerate

    generate
        if (REDIRECT_JAL) begin : g_redirect
            logic     redirect_q;
            rvga_word target_q;

            // One-cycle pulse for every accepted JAL; target held afterwards
            always_ff @(posedge clk) begin
                if (rst) begin
                    redirect_q <= 1'b0;
                    target_q   <= '0;
                end else begin
                    redirect_q <= w_in_xfer && (w_dec.opcode == OPC_JAL);
                    if (w_in_xfer && (w_dec.opcode == OPC_JAL)) begin
                        target_q <= w_dec.pc + w_dec.imm;
                    end
                end
            end

            assign decode_hazard_pc_redirect     = redirect_q;
            assign decode_hazard_redirect_target = target_q;
        end else begin : g_no_redirect
            assign decode_hazard_pc_redirect     = 1'b0;
            assign decode_hazard_redirect_target = '0;
        end
    endgenerate

    assign ifetch_decode_ready   = w_ready;
    assign decode_exec_valid     = w_out_valid;
    assign decode_exec_pc        = w_out.pc;
    assign decode_exec_opcode    = w_out.opcode;
    assign decode_exec_inst_type = w_out.itype;
    assign decode_exec_rd        = w_out.rd;
    assign decode_exec_rs1       = w_out.rs1;
    assign decode_exec_rs2       = w_out.rs2;
    assign decode_exec_funct3    = w_out.funct3;
    assign decode_exec_funct7    = w_out.funct7;
    assign decode_exec_imm       = w_out.imm;
    assign decode_exec_illegal   = w_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_rvga_decode_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvga_decode_unit
// Purpose  : Self-checking bench for rvga_decode_unit, both SKID settings
//            side by side with a shared stimulus and a FIFO-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvga_decode_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        ill;
        logic        red;
        logic [31:0] tgt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, exec_ready;
    logic [31:0] in_inst, in_pc;

    logic        o_ready [2];
    logic        o_valid [2];
    logic [31:0] o_pc    [2];
    logic [6:0]  o_opc   [2];
    logic [2:0]  o_type  [2];
    logic [4:0]  o_rd    [2];
    logic [4:0]  o_rs1   [2];
    logic [4:0]  o_rs2   [2];
    logic [2:0]  o_f3    [2];
    logic [6:0]  o_f7    [2];
    logic [31:0] o_imm   [2];
    logic        o_ill   [2];
    logic        o_red   [2];
    logic [31:0] o_tgt   [2];
    bundle_t     act     [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instance 0: SKID=0, instance 1: SKID=1
    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            rvga_decode_unit #(
                .XLEN(32), .SKID(g == 1), .REDIRECT_JAL(1'b1)
            ) u_dut (
                .clk                          (clk),
                .rst                          (rst),
                .flush                        (flush),
                .ifetch_decode_valid          (in_valid),
                .ifetch_decode_ready          (o_ready[g]),
                .ifetch_decode_instruction    (in_inst),
                .ifetch_decode_pc             (in_pc),
                .decode_exec_valid            (o_valid[g]),
                .decode_exec_ready            (exec_ready),
                .decode_exec_pc               (o_pc[g]),
                .decode_exec_opcode           (o_opc[g]),
                .decode_exec_inst_type        (o_type[g]),
                .decode_exec_rd               (o_rd[g]),
                .decode_exec_rs1              (o_rs1[g]),
                .decode_exec_rs2              (o_rs2[g]),
                .decode_exec_funct3           (o_f3[g]),
                .decode_exec_funct7           (o_f7[g]),
                .decode_exec_imm              (o_imm[g]),
                .decode_exec_illegal          (o_ill[g]),
                .decode_hazard_pc_redirect    (o_red[g]),
                .decode_hazard_redirect_target(o_tgt[g])
            );
            assign act[g] = {o_pc[g], o_opc[g], o_type[g], o_rd[g], o_rs1[g],
                             o_rs2[g], o_f3[g], o_f7[g], o_imm[g], o_ill[g]};
        end
    endgenerate

    // ---------------- reference model ----------------
    bundle_t     held    [2][2];
    int          cnt     [2];
    logic        exp_red [2];
    logic [31:0] exp_tgt [2];
    bit          chk_en = 1'b0;

    function automatic bundle_t ref_dec(input logic [31:0] inst, input logic [31:0] pc);
        bundle_t b;
        b.pc = pc; b.opcode = inst[6:0]; b.rd = inst[11:7]; b.rs1 = inst[19:15];
        b.rs2 = inst[24:20]; b.f3 = inst[14:12]; b.f7 = inst[31:25];
        b.ill = 1'b0; b.imm = 32'd0; b.itype = 3'd0;
        case (inst[6:0])
            7'h37, 7'h17: begin b.itype = 3'd4; b.imm = {12'd0, inst[31:12]} * 32'd4096; end
            7'h6F:        begin b.itype = 3'd5;
                              b.imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2; end
            7'h67, 7'h03, 7'h13: begin b.itype = 3'd1; b.imm = $signed(inst[31:20]); end
            7'h63:        begin b.itype = 3'd3;
                              b.imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2; end
            7'h23:        begin b.itype = 3'd2; b.imm = $signed({inst[31:25], inst[11:7]}); end
            7'h33:        b.itype = 3'd0;
            default:      b.ill = 1'b1;
        endcase
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model
    task automatic step();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            logic    rdy_exp, in_x, out_x;
            bundle_t nb;
            rdy_exp = (g == 1) ? (cnt[g] < 2) : (cnt[g] == 0 || exec_ready);
            if (chk_en) begin
                chk($sformatf("valid[%0d]", g), 128'(o_valid[g]), 128'(cnt[g] > 0));
                if (cnt[g] > 0)
                    chk($sformatf("bundle[%0d]", g), 128'(act[g]), 128'(held[g][0]));
                if (!rst)
                    chk($sformatf("ready[%0d]", g), 128'(o_ready[g]), 128'(rdy_exp));
                chk($sformatf("redirect[%0d]", g), 128'(o_red[g]), 128'(exp_red[g]));
                if (exp_red[g])
                    chk($sformatf("target[%0d]", g), 128'(o_tgt[g]), 128'(exp_tgt[g]));
            end
            if (rst || flush) begin
                cnt[g] = 0;
                exp_red[g] = 1'b0;
            end else begin
                out_x = (cnt[g] > 0) && exec_ready;
                in_x  = in_valid && rdy_exp;
                nb    = ref_dec(in_inst, in_pc);
                if (out_x) begin
                    held[g][0] = held[g][1];
                    cnt[g]--;
                end
                if (in_x) begin
                    held[g][cnt[g]] = nb;
                    cnt[g]++;
                end
                exp_red[g] = in_x && (in_inst[6:0] == 7'h6F);
                if (exp_red[g]) exp_tgt[g] = in_pc + nb.imm;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs [7];
    logic [6:0]  ops  [9];

    initial begin
        vecs[0] = '{32'h00500093, 32'h100, 3'd1, 5'd1,  5'd0, 3'd0, 32'h00000005, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{32'hFE000EE3, 32'h104, 3'd3, 5'd29, 5'd0, 3'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0};
        vecs[2] = '{32'h12345137, 32'h108, 3'd4, 5'd2,  5'd8, 3'd5, 32'h12345000, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{32'h008000EF, 32'h200, 3'd5, 5'd1,  5'd0, 3'd0, 32'h00000008, 1'b0, 1'b1, 32'h208};
        vecs[4] = '{32'h0000007F, 32'h300, 3'd0, 5'd0,  5'd0, 3'd0, 32'h00000000, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'h00112223, 32'h304, 3'd2, 5'd4,  5'd2, 3'd2, 32'h00000004, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{32'hFFF00093, 32'h308, 3'd1, 5'd1,  5'd0, 3'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33};

        cnt[0] = 0; cnt[1] = 0; exp_red[0] = 0; exp_red[1] = 0;
        exp_tgt[0] = 0; exp_tgt[1] = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; exec_ready = 1'b1;
        in_inst = 32'h0; in_pc = 32'h0;
        step(); step();

        // Reset state
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_valid[%0d]", g), 128'(o_valid[g]), 128'(0));
            chk($sformatf("rst_ready[%0d]", g), 128'(o_ready[g]), 128'(1));
            chk($sformatf("rst_redirect[%0d]", g), 128'(o_red[g]), 128'(0));
            chk($sformatf("rst_data[%0d]", g), 128'(act[g]), 128'(0));
            chk($sformatf("rst_target[%0d]", g), 128'(o_tgt[g]), 128'(0));
        end
        rst = 1'b0;
        chk_en = 1'b1;
        step();

        // Table-driven directed vectors
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = vecs[i].pc; exec_ready = 1'b1;
            step();
            in_valid = 1'b0;
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("v%0d_valid[%0d]", i, g), 128'(o_valid[g]), 128'(1));
                chk($sformatf("v%0d_type[%0d]", i, g), 128'(o_type[g]), 128'(vecs[i].itype));
                chk($sformatf("v%0d_rd[%0d]", i, g), 128'(o_rd[g]), 128'(vecs[i].rd));
                chk($sformatf("v%0d_rs1[%0d]", i, g), 128'(o_rs1[g]), 128'(vecs[i].rs1));
                chk($sformatf("v%0d_f3[%0d]", i, g), 128'(o_f3[g]), 128'(vecs[i].f3));
                chk($sformatf("v%0d_imm[%0d]", i, g), 128'(o_imm[g]), 128'(vecs[i].imm));
                chk($sformatf("v%0d_ill[%0d]", i, g), 128'(o_ill[g]), 128'(vecs[i].ill));
                chk($sformatf("v%0d_red[%0d]", i, g), 128'(o_red[g]), 128'(vecs[i].red));
                if (vecs[i].red)
                    chk($sformatf("v%0d_tgt[%0d]", i, g), 128'(o_tgt[g]), 128'(vecs[i].tgt));
            end
            step();
        end

        // JAL flushed in its capture cycle: no bundle, no pulse
        in_valid = 1'b1; in_inst = 32'h008000EF; in_pc = 32'h200; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("flush_valid[%0d]", g), 128'(o_valid[g]), 128'(0));
            chk($sformatf("flush_red[%0d]", g), 128'(o_red[g]), 128'(0));
        end
        step();

        // SKID=1 back-pressure: three instructions against a stalled output
        exec_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h400; step();
        in_inst = 32'h00200113; in_pc = 32'h404; step();
        chk("stall_ready_drop", 128'(o_ready[1]), 128'(0));
        chk("stall_head_pc", 128'(o_pc[1]), 128'(32'h400));
        in_inst = 32'h00300193; in_pc = 32'h408; step();
        chk("stall_hold_pc", 128'(o_pc[1]), 128'(32'h400));
        chk("stall_hold_ready", 128'(o_ready[1]), 128'(0));
        exec_ready = 1'b1; step();
        chk("drain_b_pc", 128'(o_pc[1]), 128'(32'h404));
        chk("drain_ready_back", 128'(o_ready[1]), 128'(1));
        step();
        in_valid = 1'b0;
        chk("drain_c_pc", 128'(o_pc[1]), 128'(32'h408));
        chk("drain_c_valid", 128'(o_valid[1]), 128'(1));
        step();
        chk("drain_empty", 128'(o_valid[1]), 128'(0));

        // Reset mid-stream discards held bundles
        exec_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'h00500093; in_pc = 32'h500; step();
        in_pc = 32'h504; step();
        rst = 1'b1; step();
        rst = 1'b0; in_valid = 1'b0;
        for (int g = 0; g < 2; g++)
            chk($sformatf("midrst_valid[%0d]", g), 128'(o_valid[g]), 128'(0));
        exec_ready = 1'b1;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int k;
            in_valid   = ($urandom_range(0, 9) < 7);
            exec_ready = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 24) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            in_inst    = $urandom;
            k          = $urandom_range(0, 9);
            if (k < 9) in_inst[6:0] = ops[k];
            in_pc      = $urandom;
            step();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; exec_ready = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvga_decode_unit.md
# rvga_decode_unit

Parametrised, handshaked decode stage for the rvga RV32I pipeline, placed between the instruction-fetch stage and execute. It classifies every RV32I base opcode into its instruction format and builds all six immediate formats, including the implicit zero LSB of the B and J forms. It also extracts register and function fields and flags illegal encodings. Results are held in a registered output stage with an optional skid buffer, and the block issues an early PC redirect for JAL.

## Interface
- XLEN, 32: datapath width; only 32 supported, carried for the rvga_word typedef.
- SKID, 1: 0 = single output register; 1 = output register plus one-entry skid buffer (in_ready is a flop output).
- REDIRECT_JAL, 1: 1 = compute the JAL target in decode and pulse the redirect; 0 = redirect tied low.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held instructions this cycle.
- ifetch_decode_valid  in  1  instruction/pc valid.
- ifetch_decode_ready  out  1  decode can accept.
- ifetch_decode_instruction  in  32  raw instruction.
- ifetch_decode_pc  in  32  address of the instruction.
- decode_exec_valid  out  1  decoded bundle valid.
- decode_exec_ready  in  1  execute accepts the bundle.
- decode_exec_pc  out  32  pc passthrough.
- decode_exec_opcode  out  7  inst[6:0].
- decode_exec_inst_type  out  3  rvga_inst_type (r,i,s,b,u,j).
- decode_exec_rd / rs1 / rs2  out  5 each  inst[11:7] / [19:15] / [24:20].
- decode_exec_funct3  out  3  inst[14:12].
- decode_exec_funct7  out  7  inst[31:25].
- decode_exec_imm  out  32  sign-extended immediate.
- decode_exec_illegal  out  1  unsupported opcode.
- decode_hazard_pc_redirect  out  1  one-cycle redirect pulse.
- decode_hazard_redirect_target  out  32  redirect address.

## Operation
- Opcode to type mapping:
  - LUI 0110111 and AUIPC 0010111 → u.
  - JAL 1101111 → j.
  - JALR 1100111, LOAD 0000011 and OP-IMM 0010011 → i.
  - BRANCH 1100011 → b.
  - STORE 0100011 → s.
  - OP 0110011 → r.
  - Any other opcode → r, with illegal=1 and imm=0. Every opcode yields a defined type; no latches.
- Immediates:
  - r: 0.
  - i: sext(inst[31:20]).
  - s: sext({inst[31:25],inst[11:7]}).
  - b: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - u: {inst[31:12],12'b0}.
  - j: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- Decode is combinational on the input; the result is captured on a transfer (ifetch_decode_valid & ifetch_decode_ready).
- SKID=0: ifetch_decode_ready = !decode_exec_valid | decode_exec_ready.
- SKID=1, states:
  - EMPTY: out invalid.
  - ONE: output register full.
  - TWO: output register and skid both full.
- SKID=1 transitions:
  - EMPTY → ONE on an input transfer.
  - ONE stays in ONE on simultaneous in and out transfer.
  - ONE → TWO on an input transfer without an output transfer; the new bundle goes to skid.
  - ONE → EMPTY on an output transfer only.
  - TWO → ONE on an output transfer; skid moves to the output register.
  - ifetch_decode_ready = (state != TWO), registered.
- Redirect (REDIRECT_JAL=1): when a JAL is transferred in, decode_hazard_pc_redirect=1 in the next cycle with target = pc + imm_j, computed modulo 2^32.
  - The pulse lasts exactly one cycle regardless of output stall.
  - The JAL itself still proceeds to execute to write rd.
- flush: clears all valids and state to EMPTY, and suppresses any redirect pulse due next cycle. An input presented during flush is dropped. Flush has priority over every transfer.

## Timing
- Latency: input transfer at edge N → bundle visible on decode_exec_* after edge N (one cycle).
- Throughput: one instruction per cycle while decode_exec_ready=1.
- Output stability: decode_exec_* are held stable while decode_exec_valid & !decode_exec_ready.
- Reset (synchronous):
  - decode_exec_valid=0 and decode_hazard_pc_redirect=0.
  - ifetch_decode_ready=1 after the reset edge, and also during reset for SKID=0.
  - All data outputs = 0; state EMPTY.
- Reset asserted mid-stream discards the held bundle(s) at that edge.
- Back-pressure: with SKID=1, ready deasserts only in the cycle after the second held entry is captured, so upstream loses no instruction.

## Test plan
- Reset, then send 0x00500093 (addi x1,x0,5) at pc 0x100 → next cycle: valid=1, type i, rd=1, rs1=0, funct3=0, imm=0x00000005, illegal=0.
- Send 0xFE000EE3 (beq x0,x0,-4) → type b, imm=0xFFFFFFFC, no redirect.
- Send 0x12345137 (lui x2,0x12345) → type u, rd=2, imm=0x12345000.
- Send 0x008000EF (jal x1,+8) at pc 0x200 → redirect pulse for exactly one cycle, target=0x00000208, type j, imm=8, bundle still delivered. Repeat with flush in the capture cycle → no pulse, no bundle.
- Send 0x0000007F → illegal=1, imm=0.
- SKID=1: hold decode_exec_ready=0 while streaming 3 instructions → the first two are held and ready drops. Release ready → all three delivered in order with no loss or duplication.
